// File: rtl/histo_stream_receiver.sv
// Receive side of the histogram serial stream: oversamples spi_clk/spi_mosi,
// rebuilds MSB-first words, tracks frame boundaries, totals and framing errors.
module histo_stream_receiver #(
  parameter int unsigned WORD_W          = 32,
  parameter int unsigned WORDS_PER_FRAME = 1024,
  parameter int unsigned TIMEOUT_CYCLES  = 4096,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_clk_i,
  input  logic              spi_mosi_i,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  output logic [9:0]        word_index,
  output logic              frame_start,
  output logic [7:0]        frame_id,
  output logic              frame_done,
  output logic [2:0]        frame_status,
  output logic [31:0]       pixel_total,
  output logic [1:0]        state_dbg
);

  localparam int unsigned BIN_W  = 24;
  localparam int unsigned BIT_W  = $clog2(WORD_W + 1);
  localparam int unsigned WCNT_W = $clog2(WORDS_PER_FRAME + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RECV = 2'b01,
    S_DONE = 2'b11
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;
  logic                   sclk_rise_c;
  logic                   mosi_bit_c;

  logic [WORD_W-1:0] shreg;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WCNT_W-1:0] word_cnt;
  logic [TO_W-1:0]   timeout_cnt;
  logic [31:0]       acc;
  logic              spacer_err;
  logic [32:0]       acc_sum_c;

  logic start_c;
  logic shift_c;
  logic word_c;
  logic timeout_c;

  assign sclk_rise_c = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
  assign mosi_bit_c  = mosi_sync[SYNC_STAGES-1];
  assign acc_sum_c   = {1'b0, acc} + 33'(shreg[BIN_W-1:0]);
  assign state_dbg   = state;

  // Equal-depth synchronizers keep clock and data aligned in the clk domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next state and datapath controls; edges during DONE are dropped
  always_comb begin
    state_n   = state;
    start_c   = 1'b0;
    shift_c   = 1'b0;
    word_c    = 1'b0;
    timeout_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (sclk_rise_c) begin
          state_n = S_RECV;
          start_c = 1'b1;
        end
      end
      S_RECV: begin
        if (word_cnt == WCNT_W'(WORDS_PER_FRAME)) begin
          state_n = S_DONE;
        end else if (sclk_rise_c) begin
          shift_c = 1'b1;
        end else begin
          word_c = (bit_cnt == BIT_W'(WORD_W));
          if (timeout_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_n   = S_DONE;
            timeout_c = 1'b1;
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg        <= '0;
      bit_cnt      <= '0;
      word_cnt     <= '0;
      timeout_cnt  <= '0;
      acc          <= '0;
      spacer_err   <= 1'b0;
      word_data    <= '0;
      word_valid   <= 1'b0;
      word_index   <= '0;
      frame_start  <= 1'b0;
      frame_id     <= '0;
      frame_done   <= 1'b0;
      frame_status <= '0;
      pixel_total  <= '0;
    end else begin
      word_valid  <= word_c;
      frame_start <= start_c;
      frame_done  <= (state_n == S_DONE);

      if (start_c) begin
        shreg        <= {shreg[WORD_W-2:0], mosi_bit_c};
        bit_cnt      <= BIT_W'(1);
        word_cnt     <= '0;
        timeout_cnt  <= '0;
        acc          <= '0;
        spacer_err   <= 1'b0;
        frame_status <= '0;
        pixel_total  <= '0;
      end else if (shift_c) begin
        shreg       <= {shreg[WORD_W-2:0], mosi_bit_c};
        bit_cnt     <= bit_cnt + BIT_W'(1);
        timeout_cnt <= '0;
      end else if (state == S_RECV) begin
        timeout_cnt <= timeout_cnt + TO_W'(1);
        if (word_c) begin
          word_data  <= shreg;
          word_index <= 10'(word_cnt);
          word_cnt   <= word_cnt + WCNT_W'(1);
          bit_cnt    <= '0;
          acc        <= acc_sum_c[32] ? 32'hFFFF_FFFF : acc_sum_c[31:0];
          if (word_cnt == '0)
            frame_id <= shreg[WORD_W-1 -: 8];
          else if (shreg[WORD_W-1 -: 8] != 8'h00)
            spacer_err <= 1'b1;
        end
      end

      // Close-out: status and total are published together with frame_done
      if (state_n == S_DONE) begin
        frame_status <= {spacer_err,
                         timeout_c && (bit_cnt != '0),
                         timeout_c && (word_cnt < WCNT_W'(WORDS_PER_FRAME))};
        pixel_total  <= acc;
      end
    end
  end

endmodule
